// File: rtl/sram_pkg.sv
// sram_pkg: shared address-width, way-slice and init-state definitions for the 2-port SRAM template
package sram_pkg;
    typedef enum logic {INIT, IDLE} init_state_t;
    function automatic int addr_bits(input int sets);
        return $clog2(sets);
    endfunction
    function automatic int way_lsb(input int idx, input int way_bits);
        return idx * way_bits;
    endfunction
endpackage

// File: rtl/sram_array_2p.sv
// sram_array_2p: SETS x WAYS storage, per-way masked write, registered 1-cycle read (read-before-write)
//   clock; w_en/w_addr/w_data/w_mask write port; r_en/r_addr read port; r_data valid the cycle after r_en
module sram_array_2p import sram_pkg::*; #(
    parameter int SETS     = 128,
    parameter int WAYS     = 8,
    parameter int WAY_BITS = 20
) (
    input  logic                           clock,
    input  logic                           w_en,
    input  logic [addr_bits(SETS)-1:0]     w_addr,
    input  logic [WAYS*WAY_BITS-1:0]       w_data,
    input  logic [WAYS-1:0]                w_mask,
    input  logic                           r_en,
    input  logic [addr_bits(SETS)-1:0]     r_addr,
    output logic [WAYS*WAY_BITS-1:0]       r_data
);
    for (genvar i = 0; i < WAYS; i++) begin : g_way
        logic [WAY_BITS-1:0] mem [SETS];
        always_ff @(posedge clock) begin
            if (w_en && w_mask[i])
                mem[w_addr] <= w_data[way_lsb(i, WAY_BITS) +: WAY_BITS];
            if (r_en)
                r_data[way_lsb(i, WAY_BITS) +: WAY_BITS] <= mem[r_addr];
        end
    end
endmodule

// File: rtl/sram_template_2p.sv
// sram_template_2p: two-port set/way SRAM with post-reset zeroing sweep, optional read hold and write bypass
//   clock, reset (sync, active-high); io_r_* read port (1-cycle latency); io_w_* masked write port;
//   io_init_done and both readies rise once the sweep has cleared every set
module sram_template_2p import sram_pkg::*; #(
    parameter int SETS         = 128,
    parameter int WAYS         = 8,
    parameter int WAY_BITS     = 20,
    parameter int SHOULD_RESET = 1,
    parameter int HOLD_READ    = 1,
    parameter int BYPASS_WRITE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_r_req_valid,
    output logic                       io_r_req_ready,
    input  logic [addr_bits(SETS)-1:0] io_r_addr,
    output logic [WAYS*WAY_BITS-1:0]   io_r_data,
    input  logic                       io_w_req_valid,
    output logic                       io_w_req_ready,
    input  logic [addr_bits(SETS)-1:0] io_w_addr,
    input  logic [WAYS*WAY_BITS-1:0]   io_w_data,
    input  logic [WAYS-1:0]            io_w_mask,
    output logic                       io_init_done
);
    localparam int AW = addr_bits(SETS);
    localparam int DW = WAYS * WAY_BITS;

    init_state_t         state, state_nxt;
    logic [AW-1:0]       cnt;
    logic                ready, sweep, r_acc, w_acc;
    logic                rd_pend, byp_hit;
    logic [WAYS-1:0]     byp_mask;
    logic [DW-1:0]       byp_data, arr_data, merged, hold_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= (SHOULD_RESET != 0) ? INIT : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= sweep ? cnt + 1'b1 : cnt;
        end
    end

    // SETS is a power of two, so the last set is the all-ones count
    always_comb begin
        state_nxt = (state == INIT && &cnt) ? IDLE : state;
    end

    assign ready          = (state == IDLE);
    assign sweep          = (state == INIT);
    assign r_acc          = io_r_req_valid && ready;
    assign w_acc          = io_w_req_valid && ready;
    assign io_r_req_ready = ready;
    assign io_w_req_ready = ready;
    assign io_init_done   = ready;

    sram_array_2p #(.SETS(SETS), .WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_array (
        .clock  (clock),
        .w_en   (sweep || w_acc),
        .w_addr (sweep ? cnt : io_w_addr),
        .w_data (sweep ? '0 : io_w_data),
        .w_mask (sweep ? '1 : io_w_mask),
        .r_en   (r_acc),
        .r_addr (io_r_addr),
        .r_data (arr_data)
    );

    // The array returns pre-write data; a colliding write is remembered and merged in afterwards
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            byp_hit  <= 1'b0;
            byp_mask <= '0;
            byp_data <= '0;
            hold_q   <= '0;
        end else begin
            rd_pend <= r_acc;
            if (r_acc) begin
                byp_hit  <= (BYPASS_WRITE != 0) && w_acc && (io_w_addr == io_r_addr);
                byp_mask <= io_w_mask;
                byp_data <= io_w_data;
            end
            if (rd_pend)
                hold_q <= merged;
        end
    end

    for (genvar i = 0; i < WAYS; i++) begin : g_merge
        assign merged[way_lsb(i, WAY_BITS) +: WAY_BITS] = (byp_hit && byp_mask[i]) ?
            byp_data[way_lsb(i, WAY_BITS) +: WAY_BITS] : arr_data[way_lsb(i, WAY_BITS) +: WAY_BITS];
    end

    assign io_r_data = (HOLD_READ != 0) ? (rd_pend ? merged : hold_q) : merged;
endmodule
